// File: rtl/fcmp_reduce_pkg.sv
// Shared encodings for the float min/max reduction engine:
// FSM states, comparator opcodes and reduction modes.
package fcmp_reduce_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFirst = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam logic [2:0] CMP_GT = 3'b110;
    localparam logic [2:0] CMP_EQ = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b101;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/compf.sv
// Combinational IEEE-754 single-precision comparator: result = (a inst b).
// Orders by sign, then exponent, then mantissa; +0 and -0 compare equal, no NaN handling.
module compf
    import fcmp_reduce_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  inst,
    output logic        result
);

    logic both_zero;
    logic is_eq;
    logic is_gt;
    logic is_lt;

    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

    always_comb begin
        is_eq = 1'b0;
        is_gt = 1'b0;
        if (both_zero || (a == b)) begin
            is_eq = 1'b1;
        end else if (a[31] != b[31]) begin
            is_gt = b[31];
        end else if (!a[31]) begin
            is_gt = a[30:0] > b[30:0];
        end else begin
            // Both negative: the larger magnitude is the smaller value.
            is_gt = a[30:0] < b[30:0];
        end
    end

    assign is_lt = !is_gt && !is_eq;

    always_comb begin
        case (inst)
            CMP_GT:  result = is_gt;
            CMP_EQ:  result = is_eq;
            CMP_LT:  result = is_lt;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/fcmp_reduce.sv
// Streaming min/max reduction over single-precision floats: tracks the running
// best value and its index, then presents the winner on a valid/ready output.
module fcmp_reduce
    import fcmp_reduce_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [IDX_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_value,
    output logic [IDX_W-1:0] out_index,
    output logic             out_empty,
    output logic             busy
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_t           state;
    logic             mode_q;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] elem;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      best;

    logic [2:0]       cmp_op;
    logic             cmp_hit;
    logic             hs;
    logic             last;
    logic [31:0]      next_best;
    logic [IDX_W-1:0] next_idx;

    assign in_ready  = (state == StFirst) || (state == StRun);
    assign out_valid = (state == StDone);
    assign busy      = (state != StIdle);
    assign hs        = in_valid && in_ready;

    always_comb begin
        cmp_op    = (mode_q == MODE_MIN) ? CMP_LT : CMP_GT;
        next_best = cmp_hit ? in_data : best;
        next_idx  = cmp_hit ? elem : best_idx;
        last      = (elem == (count_q - ONE));
    end

    compf u_compf (
        .a      (in_data),
        .b      (best),
        .inst   (cmp_op),
        .result (cmp_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            mode_q    <= MODE_MAX;
            count_q   <= '0;
            elem      <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_value <= '0;
            out_index <= '0;
            out_empty <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        mode_q  <= mode;
                        count_q <= count;
                        elem    <= '0;
                        if (count == '0) begin
                            out_value <= '0;
                            out_index <= '0;
                            out_empty <= 1'b1;
                            state     <= StDone;
                        end else begin
                            out_empty <= 1'b0;
                            state     <= StFirst;
                        end
                    end
                end
                StFirst: begin
                    if (hs) begin
                        best     <= in_data;
                        best_idx <= '0;
                        elem     <= ONE;
                        if (count_q == ONE) begin
                            out_value <= in_data;
                            out_index <= '0;
                            state     <= StDone;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (hs) begin
                        best     <= next_best;
                        best_idx <= next_idx;
                        elem     <= elem + ONE;
                        if (last) begin
                            out_value <= next_best;
                            out_index <= next_idx;
                            state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fcmp_reduce.sv
// Directed and gated-random bench for fcmp_reduce with an ordering-key reference model.
module tb_fcmp_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [7:0]  out_index;
    logic        out_empty;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] vec [256];

    fcmp_reduce #(.IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_index (out_index),
        .out_empty (out_empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Map a float onto an unsigned key whose natural order is the float order.
    function automatic logic [31:0] fkey(input logic [31:0] f);
        if (f[30:0] == 31'd0) return 32'h8000_0000;
        else if (!f[31]) return {1'b1, f[30:0]};
        else return {1'b0, ~f[30:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic m, input logic [7:0] c);
        start = 1'b1;
        mode  = m;
        count = c;
        tick();
        start = 1'b0;
        mode  = ~m;
        count = 8'd0;
    endtask

    task automatic stream(input int c, input bit gate, input bit noise);
        int i = 0;
        int cyc = 0;
        bit hs;
        while (i < c && cyc < 3000) begin
            in_valid = gate ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? vec[i] : $urandom;
            if (noise) begin
                start = ($urandom_range(0, 3) == 0);
                count = 8'($urandom_range(0, 255));
                mode  = 1'($urandom_range(0, 1));
            end
            hs = in_valid && in_ready;
            tick();
            if (hs) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        total++;
        if (i != c) begin
            bad++;
            $display("FAIL stream_timeout: accepted=%0d required=%0d", i, c);
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total += 6;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
        if (out_value !== 32'h0) begin bad++; $display("FAIL reset_out_value: got=%h exp=0", out_value); end
        if (out_index !== 8'h0) begin bad++; $display("FAIL reset_out_index: got=%0d exp=0", out_index); end
        if (out_empty !== 1'b0) begin bad++; $display("FAIL reset_out_empty: got=%b exp=0", out_empty); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    endtask

    task automatic load4();
        vec[0] = 32'h3F80_0000;
        vec[1] = 32'hC040_0000;
        vec[2] = 32'h4000_0000;
        vec[3] = 32'h3F00_0000;
    endtask

    task automatic test_max();
        load4();
        start_run(1'b0, 8'd4);
        stream(4, 1'b0, 1'b0);
        total += 5;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL max_latency: out_valid=%b exp=1", out_valid); end
        if (out_value !== 32'h4000_0000) begin bad++; $display("FAIL max_value: got=%h exp=40000000", out_value); end
        if (out_index !== 8'd2) begin bad++; $display("FAIL max_index: got=%0d exp=2", out_index); end
        if (out_empty !== 1'b0) begin bad++; $display("FAIL max_empty: got=%b exp=0", out_empty); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL max_done_in_ready: got=%b exp=0", in_ready); end
        pop();
    endtask

    task automatic test_min_hold();
        load4();
        start_run(1'b1, 8'd4);
        stream(4, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got=%b exp=1", k, out_valid); end
            if (out_value !== 32'hC040_0000) begin bad++; $display("FAIL hold_value[%0d]: got=%h exp=c0400000", k, out_value); end
            if (out_index !== 8'd1) begin bad++; $display("FAIL hold_index[%0d]: got=%0d exp=1", k, out_index); end
            if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy[%0d]: got=%b exp=1", k, busy); end
            tick();
        end
        pop();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL pop_valid: got=%b exp=0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL pop_busy: got=%b exp=0", busy); end
    endtask

    task automatic test_zero_tie();
        vec[0] = 32'h0000_0000;
        vec[1] = 32'h8000_0000;
        vec[2] = 32'h0000_0000;
        start_run(1'b0, 8'd3);
        stream(3, 1'b0, 1'b0);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL tie_valid: got=%b exp=1", out_valid); end
        if (out_value !== 32'h0) begin bad++; $display("FAIL tie_value: got=%h exp=0", out_value); end
        if (out_index !== 8'd0) begin bad++; $display("FAIL tie_index: got=%0d exp=0", out_index); end
        pop();
    endtask

    task automatic test_empty_single();
        start_run(1'b1, 8'd0);
        total += 5;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL empty_valid: got=%b exp=1", out_valid); end
        if (out_empty !== 1'b1) begin bad++; $display("FAIL empty_flag: got=%b exp=1", out_empty); end
        if (out_value !== 32'h0) begin bad++; $display("FAIL empty_value: got=%h exp=0", out_value); end
        if (out_index !== 8'd0) begin bad++; $display("FAIL empty_index: got=%0d exp=0", out_index); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL empty_in_ready: got=%b exp=0", in_ready); end
        pop();
        vec[0] = 32'hC040_0000;
        start_run(1'b0, 8'd1);
        stream(1, 1'b0, 1'b0);
        total += 4;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got=%b exp=1", out_valid); end
        if (out_value !== 32'hC040_0000) begin bad++; $display("FAIL single_value: got=%h exp=c0400000", out_value); end
        if (out_index !== 8'd0) begin bad++; $display("FAIL single_index: got=%0d exp=0", out_index); end
        if (out_empty !== 1'b0) begin bad++; $display("FAIL single_empty: got=%b exp=0", out_empty); end
        pop();
    endtask

    task automatic test_random(input logic m);
        logic [31:0] exp_v;
        logic [7:0]  exp_i;
        for (int i = 0; i < 255; i++) begin
            // Mix in signed zeros and repeats so ties and sign handling get exercised.
            case ($urandom_range(0, 7))
                0: vec[i] = 32'h8000_0000;
                1: vec[i] = (i > 0) ? vec[i-1] : 32'h0;
                default: vec[i] = $urandom;
            endcase
        end
        exp_v = vec[0];
        exp_i = 8'd0;
        for (int i = 1; i < 255; i++) begin
            if (m ? (fkey(vec[i]) < fkey(exp_v)) : (fkey(vec[i]) > fkey(exp_v))) begin
                exp_v = vec[i];
                exp_i = 8'(i);
            end
        end
        start_run(m, 8'd255);
        stream(255, 1'b1, 1'b1);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rand_valid(m=%0d): got=%b exp=1", m, out_valid); end
        if (out_value !== exp_v) begin bad++; $display("FAIL rand_value(m=%0d): got=%h exp=%h", m, out_value, exp_v); end
        if (out_index !== exp_i) begin bad++; $display("FAIL rand_index(m=%0d): got=%0d exp=%0d", m, out_index, exp_i); end
        pop();
    endtask

    task automatic test_abort();
        vec[0] = 32'h4200_0000;
        vec[1] = 32'h4300_0000;
        start_run(1'b0, 8'd4);
        stream(2, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        vec[0] = 32'hBF80_0000;
        vec[1] = 32'hC000_0000;
        vec[2] = 32'h3E80_0000;
        vec[3] = 32'h3E80_0000;
        start_run(1'b0, 8'd4);
        stream(4, 1'b0, 1'b0);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL abort_valid: got=%b exp=1", out_valid); end
        if (out_value !== 32'h3E80_0000) begin bad++; $display("FAIL abort_value: got=%h exp=3e800000", out_value); end
        if (out_index !== 8'd2) begin bad++; $display("FAIL abort_index: got=%0d exp=2", out_index); end
        pop();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        count     = 8'd0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        tick();
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_max();
        test_min_hold();
        test_zero_tie();
        test_empty_single();
        test_random(1'b0);
        test_random(1'b1);
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcmp_reduce.md
Name: fcmp_reduce

Overview:
Streaming min/max reduction engine over IEEE-754 single-precision operands. Accepts a programmed count of floats on a valid/ready input stream, keeps a running best value and its index, and presents the winner on a valid/ready output stream. Sequences one combinational float comparator, one comparison per accepted element. Sits between an operand source (register file / load unit) and the ALU result path.

Parameters:
IDX_W, 8, width of element count and index; max count = 2^IDX_W - 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a reduction; sampled only in IDLE
mode  in  1  0 = maximum, 1 = minimum; latched at start
count  in  IDX_W  number of elements; latched at start
in_valid  in  1  input element valid
in_ready  out  1  engine accepts element this cycle
in_data  in  32  input float
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_value  out  32  winning float
out_index  out  IDX_W  zero-based position of winner in stream
out_empty  out  1  reduction had count = 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0, out_valid=0, out_value=0, out_index=0, out_empty=0, busy=0; internal counters and latched mode/count cleared. Reset mid-reduction discards all progress; no result is emitted.
- States: IDLE, FIRST, RUN, DONE.
- IDLE: start=1 latches mode and count, clears elem counter. count=0 -> DONE with out_value=0, out_index=0, out_empty=1. Otherwise -> FIRST, out_empty=0.
- FIRST: in_ready=1. On in_valid&in_ready: best<=in_data, best_idx<=0, elem<=1; -> DONE if count=1, else RUN. No comparison is made on the first element.
- RUN: in_ready=1. On handshake: comparator evaluates in_data against best. mode=0 uses greater-than, mode=1 uses less-than, strict in both cases. If true, best<=in_data and best_idx<=elem. elem<=elem+1. When the accepted element is number count-1 (elem = count-1), -> DONE.
- DONE: out_valid=1, out_value=best, out_index=best_idx. Outputs hold stable while out_valid=1 and out_ready=0. On out_ready=1 -> IDLE and out_valid clears next cycle.
- Latency: out_valid rises the cycle after the last input handshake, or the cycle after start when count=0. Throughput is one element per cycle with no bubbles.
- start outside IDLE: ignored. in_valid in IDLE/DONE: ignored, in_ready=0.
- Ties: strict compare, so the earliest index wins. +0 (0x00000000) and -0 (0x80000000) compare equal.
- Ordering: sign, then biased exponent, then mantissa. There is no NaN/Inf special handling; NaN patterns order by their bit fields.
- Comparator op is always driven to a defined code (greater 3'b110 / less 3'b101), so the comparator output is never left undriven.
- out_value/out_index update only on the DONE transition. Between reductions they retain the last result.

Decomposition:
- Shared package: state encoding (IDLE/FIRST/RUN/DONE), comparator opcodes CMP_GT=3'b110, CMP_EQ=3'b100, CMP_LT=3'b101, MODE_MAX=0, MODE_MIN=1.
- Sub-module: instantiate the existing float comparator compf, with a = in_data, b = best, inst from mode. All sequencing stays in fcmp_reduce.

Test Plan:
- mode=0, count=4, stream 0x3F800000(1.0), 0xC0400000(-3.0), 0x40000000(2.0), 0x3F000000(0.5), in_valid held high -> out_valid 1 cycle after 4th handshake; out_value=0x40000000, out_index=2, out_empty=0.
- Same stream with mode=1 -> out_value=0xC0400000, out_index=1. Hold out_ready=0 for 5 cycles -> outputs stable, busy=1; out_ready=1 -> IDLE next cycle.
- mode=0, count=3, stream 0x00000000, 0x80000000, 0x00000000 -> out_value=0x00000000, out_index=0 (tie keeps first).
- count=0 with start -> out_valid next cycle, out_empty=1, out_value=0, out_index=0. count=1 stream 0xC0400000 -> out_value=0xC0400000, out_index=0.
- Randomly gated in_valid (50%) over count=255 random floats, any mode -> result matches the reference model. start pulses while busy have no effect.
- Assert rst during RUN after 2 of 4 elements -> all outputs 0 immediately. A fresh start then reduces correctly, with no residue from the aborted run.
